// File: rtl/rf_debug_dumper_pkg.sv
// Shared types for the register-file debug dumper: widths, bus aliases and FSM states.
package rf_debug_dumper_pkg;

  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned RF_NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] logic5;
  typedef logic [DATA_W-1:0] logic32;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/rf_debug_dumper_if.sv
// DebugBus read port plus the outgoing dump beat stream.
interface rf_debug_dumper_if;
  import rf_debug_dumper_pkg::*;

  logic5  rf_ra;
  logic32 rf_rd;
  logic   dump_valid;
  logic   dump_ready;
  logic5  dump_addr;
  logic32 dump_data;

  modport master (
    output rf_ra,
    input  rf_rd,
    output dump_valid,
    input  dump_ready,
    output dump_addr,
    output dump_data
  );

  modport slave (
    input  rf_ra,
    output rf_rd,
    input  dump_valid,
    output dump_ready,
    input  dump_addr,
    input  dump_data
  );

endinterface

// File: rtl/rf_debug_dumper.sv
// Sweeps a register range over the DebugBus read port and streams each value out,
// accumulating an XOR checksum and a beat count.
module rf_debug_dumper
  import rf_debug_dumper_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic5              first_reg,
  input  logic5              last_reg,
  rf_debug_dumper_if.master  dbg,
  output logic               busy,
  output logic               done,
  output logic               range_err,
  output logic32             checksum,
  output cnt_t               count
);

  dump_state_t state_q, state_d;
  logic5       idx_q, idx_d;
  logic5       last_q, last_d;
  logic5       rf_ra_q, rf_ra_d;
  logic        dump_valid_q, dump_valid_d;
  logic5       dump_addr_q, dump_addr_d;
  logic32      dump_data_q, dump_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        range_err_q, range_err_d;
  logic32      checksum_q, checksum_d;
  cnt_t        count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      last_q       <= '0;
      rf_ra_q      <= '0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      range_err_q  <= 1'b0;
      checksum_q   <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      rf_ra_q      <= rf_ra_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      range_err_q  <= range_err_d;
      checksum_q   <= checksum_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    dump_valid_d = dump_valid_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    range_err_d  = range_err_q;
    checksum_d   = checksum_q;
    count_d      = count_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          checksum_d = '0;
          count_d    = '0;
          if (first_reg <= last_reg) begin
            state_d     = READ;
            idx_d       = first_reg;
            last_d      = last_reg;
            range_err_d = 1'b0;
          end else begin
            state_d     = DONE;
            range_err_d = 1'b1;
          end
        end
      end
      READ: begin
        dump_data_d  = dbg.rf_rd;
        dump_addr_d  = idx_q;
        dump_valid_d = 1'b1;
        state_d      = SEND;
      end
      SEND: begin
        if (dump_valid_q && dbg.dump_ready) begin
          checksum_d   = checksum_q ^ dump_data_q;
          count_d      = count_q + CNT_W'(1);
          dump_valid_d = 1'b0;
          // Compare before increment so a range ending at the top register never wraps.
          if (idx_q == last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything, including a same-cycle handshake.
    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      idx_d        = idx_q;
      dump_valid_d = 1'b0;
      checksum_d   = checksum_q;
      count_d      = count_q;
    end

    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    rf_ra_d = ((state_d == READ) || (state_d == SEND)) ? idx_d : '0;
  end

  assign dbg.rf_ra      = rf_ra_q;
  assign dbg.dump_valid = dump_valid_q;
  assign dbg.dump_addr  = dump_addr_q;
  assign dbg.dump_data  = dump_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign range_err      = range_err_q;
  assign checksum       = checksum_q;
  assign count          = count_q;

endmodule

// File: tb/tb_rf_debug_dumper.sv
// Directed + randomized bench for rf_debug_dumper against a queue-based dump model.
module tb_rf_debug_dumper;
  import rf_debug_dumper_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   start;
  logic   abort;
  logic5  first_reg;
  logic5  last_reg;
  logic   busy;
  logic   done;
  logic   range_err;
  logic32 checksum;
  cnt_t   count;

  rf_debug_dumper_if dbg ();

  logic32 rf [RF_NUM_REGS];
  assign dbg.rf_rd = rf[dbg.rf_ra];

  rf_debug_dumper dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .dbg       (dbg.master),
    .busy      (busy),
    .done      (done),
    .range_err (range_err),
    .checksum  (checksum),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one dump from first f to last l; the model is simply the list of (index, rf[index]).
  task automatic run_dump(input logic5 f, input logic5 l, input int pct,
                          input int stall_addr, input int abort_beat, input bit poke_start);
    logic32 q_addr [$];
    logic32 q_data [$];
    logic32 exp_sum;
    int     n_regs;
    int     beats;
    int     first_v;
    int     done_k;
    int     stall;
    bit     aborted;
    bit     rdy;
    exp_sum = '0;
    beats   = 0;
    first_v = -1;
    done_k  = -1;
    stall   = 0;
    aborted = 1'b0;
    if (f <= l) begin
      for (int i = int'(f); i <= int'(l); i++) begin
        q_addr.push_back(32'(i));
        q_data.push_back(rf[i]);
      end
    end
    n_regs = q_addr.size();

    @(negedge clk);
    start = 1'b1; first_reg = f; last_reg = l;
    @(negedge clk);
    start = 1'b0; first_reg = logic5'($urandom); last_reg = logic5'($urandom);

    for (int k = 1; k <= 300; k++) begin
      if (done) begin
        done_k = k;
        break;
      end
      if (dbg.dump_valid) begin
        if (first_v < 0) first_v = k;
        if (q_addr.size() == 0) begin
          chk("extra beat", 32'(dbg.dump_addr), 32'hFFFF_FFFF);
        end else begin
          chk("beat addr", 32'(dbg.dump_addr), q_addr[0]);
          chk("beat data", dbg.dump_data, q_data[0]);
        end
      end
      rdy = ($urandom_range(0, 99) < pct);
      if (dbg.dump_valid && int'(dbg.dump_addr) == stall_addr && stall < 5) begin
        rdy = 1'b0;
        stall++;
      end
      dbg.dump_ready = rdy;
      if (poke_start && k == 3) begin
        start = 1'b1; first_reg = 5'd0; last_reg = 5'd0;
      end else begin
        start = 1'b0;
      end
      if (dbg.dump_valid && beats == abort_beat) begin
        abort = 1'b1;
        dbg.dump_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort valid", 32'(dbg.dump_valid), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        aborted = 1'b1;
        break;
      end
      if (dbg.dump_valid && rdy && q_data.size() != 0) begin
        exp_sum = exp_sum ^ q_data.pop_front();
        void'(q_addr.pop_front());
        beats++;
      end
      @(negedge clk);
    end
    start = 1'b0;

    if (!aborted) begin
      chk("done seen", 32'(done_k > 0), 32'd1);
      if (n_regs > 0) chk("first valid latency", 32'(first_v), 32'd2);
      else            chk("no beat on range err", 32'(first_v), 32'hFFFF_FFFF);
      if (pct == 100 && stall_addr < 0) chk("done cycle", 32'(done_k), 32'(2 * n_regs + 1));
      chk("queue drained", 32'(q_addr.size()), 32'd0);
      @(negedge clk);
      chk("done single pulse", 32'(done), 32'd0);
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle rf_ra", 32'(dbg.rf_ra), 32'd0);
    end
    chk("count", 32'(count), 32'(beats));
    chk("checksum", checksum, exp_sum);
    chk("range_err", 32'(range_err), 32'(f > l));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    first_reg = '0; last_reg = '0; dbg.dump_ready = 1'b0;
    for (int i = 0; i < int'(RF_NUM_REGS); i++) rf[i] = $urandom;
    #12;
    chk("rst rf_ra", 32'(dbg.rf_ra), 32'd0);
    chk("rst valid", 32'(dbg.dump_valid), 32'd0);
    chk("rst addr", 32'(dbg.dump_addr), 32'd0);
    chk("rst data", dbg.dump_data, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst range_err", 32'(range_err), 32'd0);
    chk("rst checksum", checksum, 32'd0);
    chk("rst count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three-register dump with known values.
    rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h44;
    run_dump(5'd1, 5'd3, 100, -1, -1, 1'b0);
    chk("tp1 checksum const", checksum, 32'h77);
    chk("tp1 count const", 32'(count), 32'd3);

    // Full sweep, rN = N, with a stray start while busy.
    for (int i = 0; i < int'(RF_NUM_REGS); i++) rf[i] = 32'(i);
    run_dump(5'd0, 5'd31, 100, -1, -1, 1'b1);
    chk("sweep count const", 32'(count), 32'd32);
    chk("sweep checksum const", checksum, 32'd0);

    // Back-pressure on r2.
    for (int i = 0; i < int'(RF_NUM_REGS); i++) rf[i] = $urandom;
    run_dump(5'd0, 5'd5, 100, 2, -1, 1'b0);

    // Rejected range, then a valid start clears the flag.
    run_dump(5'd7, 5'd4, 100, -1, -1, 1'b0);
    run_dump(5'd2, 5'd2, 60, -1, -1, 1'b0);

    // Abort on the second beat, then a clean run.
    run_dump(5'd1, 5'd5, 100, -1, 1, 1'b0);
    chk("abort partial count", 32'(count), 32'd1);
    chk("abort partial checksum", checksum, rf[1]);
    run_dump(5'd3, 5'd9, 50, -1, -1, 1'b0);

    // start and abort together in IDLE.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; first_reg = 5'd0; last_reg = 5'd4;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start+abort busy", 32'(busy), 32'd0);
    chk("start+abort done", 32'(done), 32'd0);

    // Asynchronous reset mid-SEND.
    dbg.dump_ready = 1'b0;
    start = 1'b1; first_reg = 5'd4; last_reg = 5'd8;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10 && !dbg.dump_valid; k++) @(negedge clk);
    chk("pre-reset valid", 32'(dbg.dump_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", 32'(dbg.dump_valid), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst rf_ra", 32'(dbg.rf_ra), 32'd0);
    chk("async rst done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_dump(5'd4, 5'd8, 70, -1, -1, 1'b0);

    // Random ranges and back-pressure.
    for (int r = 0; r < 6; r++) begin
      logic5 a;
      logic5 b;
      a = logic5'($urandom);
      b = logic5'($urandom);
      for (int i = 0; i < int'(RF_NUM_REGS); i++) rf[i] = $urandom;
      if (r == 5) run_dump(a, b, 100, -1, -1, 1'b0);
      else        run_dump((a < b) ? a : b, (a < b) ? b : a, $urandom_range(30, 100), -1, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
